rock_step_scheduler: RTL and testbench
======================================

// Module: rock_step_scheduler
// PURPOSE
//  Sequences the rocker's amplitude (A) and frequency (F) levels from heart-rate stress evaluations.
//  Each evaluation leads to at most one level step; after every step the block waits a settle window.
//  Sits between the stress evaluator (stable/decreased/risen flags) and the rocker drive datapath.
//  Owns the A/F level registers and issues one-cycle step strobes to the drive.
// PARAMETERS
//  LVL_W        3   width of A and F level registers
//  LVL_MAX      4   reset/start level for A and F; F never exceeds it
//  SETTLE_TICKS 8   slow ticks to wait after any step before an evaluation is accepted
//  EVAL_TIMEOUT 16  slow ticks allowed in WAIT_EVAL without eval_valid before FAULT
//  ERR_LIMIT    3   consecutive eval_err results that force FAULT
// PORTS
//  clk        in   1      system clock (single clock domain)
//  reset      in   1      synchronous, active-high reset
//  tick       in   1      one-clk slow-time enable pulse
//  eval_valid in   1      one-clk pulse: heart rate stable, evaluation result valid
//  eval_down  in   1      qualified by eval_valid: rate decreased since last evaluation
//  eval_err   in   1      qualified by eval_valid: rate increased since last evaluation
//  A          out  LVL_W  current amplitude level
//  F          out  LVL_W  current frequency level
//  amp_dec    out  1      one-clk strobe: A is decremented
//  freq_inc   out  1      one-clk strobe: F is incremented
//  freq_dec   out  1      one-clk strobe: F is decremented
//  done       out  1      sticky: A reached 0, rocking finished
//  fault      out  1      sticky: timeout or error limit reached
//  state      out  3      FSM state, for debug
// BEHAVIOUR
//  Reset (synchronous): A=F=LVL_MAX; state=SETTLE; counters, err_cnt and prev_down = 0; all strobes, done and fault = 0.
//  SETTLE: count ticks 0..SETTLE_TICKS-1, ignoring eval_valid. On tick with count==SETTLE_TICKS-1, go to WAIT_EVAL and clear count.
//  WAIT_EVAL: each tick increments the timeout count. Timeout count reaching EVAL_TIMEOUT -> FAULT.
//   On eval_valid, latch the decision and go to STEP; eval_valid wins over a tick in the same cycle (count not incremented).
//  Decision, first match:
//   1. eval_err: err_cnt+1; if it reaches ERR_LIMIT -> FAULT, else freq_inc (saturates: no strobe if F==LVL_MAX).
//   2. eval_down & prev_down: amp_dec.
//   3. eval_down & !prev_down: no step; prev_down=1; back to SETTLE.
//   4. otherwise: freq_dec if F>0; else amp_dec if A>0.
//   eval_down clears err_cnt; prev_down := eval_down for rules 2 and 4.
//  STEP: lasts exactly one cycle; exactly one strobe is high; A/F are updated at the edge leaving STEP.
//   If the new A==0 -> DONE, otherwise -> SETTLE.
//   Latency: eval_valid sampled at edge N -> strobe high in cycle N+1 -> A/F new value visible from N+2.
//  DONE / FAULT: sticky until reset; A/F held; no strobes; inputs ignored.
//  Bounds: A and F never wrap. A decrement at A==0 and F decrement at F==0 are impossible by rule order.
//  Reset asserted in any state, including STEP, wins on that edge and suppresses strobes.
//  eval_down/eval_err are don't-care without eval_valid; both high together -> eval_err rule.
// STRUCTURE
//  Shared package rock_pkg: state encodings (SETTLE=0, WAIT_EVAL=1, STEP=2, DONE=3, FAULT=4), step-code localparams, default LVL_W/LVL_MAX.
//  One sub-module: tick_counter (tick-enabled up-counter with sync clear and terminal-count flag).
//   It is instanced once and shared by SETTLE and WAIT_EVAL, and cleared on every state entry.
// TESTING
//  1. Reset, then 8 ticks -> state=WAIT_EVAL; no strobes during SETTLE; A=F=4.
//  2. eval_valid, eval_down=0 -> freq_dec 1 cycle later; F=3 the cycle after that; state=SETTLE.
//  3. eval_down=1 twice, each after settle -> first: no strobe; second: amp_dec, A=3.
//  4. 3 consecutive eval_err -> freq_inc after the first two (F saturated at 4, no strobe); fault=1 on the third; later inputs ignored.
//  5. In WAIT_EVAL, 16 ticks without eval_valid -> fault=1. Separately, eval_valid on the same cycle as the 16th tick -> STEP, no fault.
//  6. Drive F to 0, then A down to 0 -> done=1 after the last amp_dec. Reset mid-STEP -> no strobe, A=F=4.

Source files
------------

// File: rtl/rock_pkg.sv
// Shared types for the rocker step scheduler: FSM state encoding,
// step codes and default level sizing.
package rock_pkg;

    localparam int LVL_W_DEF   = 3;
    localparam int LVL_MAX_DEF = 4;

    typedef enum logic [2:0] {
        S_SETTLE    = 3'd0,
        S_WAIT_EVAL = 3'd1,
        S_STEP      = 3'd2,
        S_DONE      = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [1:0] STEP_NONE     = 2'd0;
    localparam logic [1:0] STEP_AMP_DEC  = 2'd1;
    localparam logic [1:0] STEP_FREQ_INC = 2'd2;
    localparam logic [1:0] STEP_FREQ_DEC = 2'd3;

endpackage

// File: rtl/tick_counter.sv
// Tick-enabled up-counter with synchronous clear and a terminal flag.
// Ports: clk, reset (sync, active-high), clr, en, limit -> at_limit.
module tick_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // High while the count sits on its last value, so the next
    // enabled tick is the terminal one.
    assign at_limit = (count == limit);

endmodule

// File: rtl/rock_step_scheduler.sv
// Sequences rocker amplitude/frequency levels from stress evaluations.
// Ports: clk, reset, tick, eval_valid/down/err in; A, F, step strobes,
// done, fault and debug state out.
module rock_step_scheduler
    import rock_pkg::*;
#(
    parameter int LVL_W        = LVL_W_DEF,
    parameter int LVL_MAX      = LVL_MAX_DEF,
    parameter int SETTLE_TICKS = 8,
    parameter int EVAL_TIMEOUT = 16,
    parameter int ERR_LIMIT    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             eval_valid,
    input  logic             eval_down,
    input  logic             eval_err,
    output logic [LVL_W-1:0] A,
    output logic [LVL_W-1:0] F,
    output logic             amp_dec,
    output logic             freq_inc,
    output logic             freq_dec,
    output logic             done,
    output logic             fault,
    output logic [2:0]       state
);

    localparam int CNT_MAX = (SETTLE_TICKS > EVAL_TIMEOUT) ?
                             SETTLE_TICKS : EVAL_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ERR_W   = $clog2(ERR_LIMIT + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(EVAL_TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_TOP      = LVL_W'(LVL_MAX);
    localparam logic [ERR_W-1:0] ERR_TOP      = ERR_W'(ERR_LIMIT);

    state_t           state_q, state_d;
    logic [LVL_W-1:0] a_q, a_d, f_q, f_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             prev_q, prev_d;
    logic [1:0]       code_q, code_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_limit;
    logic             cnt_last;

    // One counter serves both the settle window and the eval timeout;
    // it restarts on every state change.
    tick_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .limit    (cnt_limit),
        .at_limit (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_SETTLE;
            a_q     <= LVL_TOP;
            f_q     <= LVL_TOP;
            err_q   <= '0;
            prev_q  <= 1'b0;
            code_q  <= STEP_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            f_q     <= f_d;
            err_q   <= err_d;
            prev_q  <= prev_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        f_d       = f_q;
        err_d     = err_q;
        prev_d    = prev_q;
        code_d    = code_q;
        cnt_limit = SETTLE_LAST;
        cnt_en    = 1'b0;

        case (state_q)
            S_SETTLE: begin
                cnt_en = tick;
                if (tick && cnt_last) begin
                    state_d = S_WAIT_EVAL;
                end
            end
            S_WAIT_EVAL: begin
                cnt_limit = TIMEOUT_LAST;
                cnt_en    = tick && !eval_valid;
                if (eval_valid) begin
                    if (eval_err) begin
                        err_d = err_q + ERR_W'(1);
                        if (err_d == ERR_TOP) begin
                            state_d = S_FAULT;
                        end else if (f_q == LVL_TOP) begin
                            // Frequency already at the top: no step.
                            state_d = S_SETTLE;
                        end else begin
                            code_d  = STEP_FREQ_INC;
                            state_d = S_STEP;
                        end
                    end else if (eval_down && prev_q) begin
                        err_d   = '0;
                        prev_d  = 1'b1;
                        code_d  = STEP_AMP_DEC;
                        state_d = S_STEP;
                    end else if (eval_down) begin
                        // First decrease only arms the amplitude step.
                        err_d   = '0;
                        prev_d  = 1'b1;
                        state_d = S_SETTLE;
                    end else begin
                        prev_d  = 1'b0;
                        code_d  = (f_q != '0) ? STEP_FREQ_DEC : STEP_AMP_DEC;
                        state_d = S_STEP;
                    end
                end else if (tick && cnt_last) begin
                    state_d = S_FAULT;
                end
            end
            S_STEP: begin
                case (code_q)
                    STEP_AMP_DEC:  a_d = a_q - LVL_W'(1);
                    STEP_FREQ_INC: f_d = f_q + LVL_W'(1);
                    STEP_FREQ_DEC: f_d = f_q - LVL_W'(1);
                    default:       a_d = a_q;
                endcase
                state_d = (a_d == '0) ? S_DONE : S_SETTLE;
            end
            S_DONE:  state_d = S_DONE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        cnt_clr = (state_d != state_q);
    end

    logic in_step;
    assign in_step  = (state_q == S_STEP) && !reset;

    assign amp_dec  = in_step && (code_q == STEP_AMP_DEC);
    assign freq_inc = in_step && (code_q == STEP_FREQ_INC);
    assign freq_dec = in_step && (code_q == STEP_FREQ_DEC);

    assign A     = a_q;
    assign F     = f_q;
    assign done  = (state_q == S_DONE);
    assign fault = (state_q == S_FAULT);
    assign state = state_q;

endmodule

// File: tb/tb_rock_step_scheduler.sv
// Scoreboard bench for rock_step_scheduler: stimulus queues expected
// strobes and post-step levels, a monitor pops and compares them.
module tb_rock_step_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       eval_valid = 1'b0;
    logic       eval_down = 1'b0;
    logic       eval_err = 1'b0;
    logic [2:0] A, F;
    logic       amp_dec, freq_inc, freq_dec, done, fault;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] stb;
        logic [7:0] a;
        logic [7:0] f;
    } exp_t;

    exp_t sbq[$];

    localparam logic [2:0] X_AMP = 3'b100;
    localparam logic [2:0] X_INC = 3'b010;
    localparam logic [2:0] X_DEC = 3'b001;

    always #5 clk = ~clk;

    rock_step_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .eval_valid (eval_valid),
        .eval_down  (eval_down),
        .eval_err   (eval_err),
        .A          (A),
        .F          (F),
        .amp_dec    (amp_dec),
        .freq_inc   (freq_inc),
        .freq_dec   (freq_dec),
        .done       (done),
        .fault      (fault),
        .state      (state)
    );

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic v,
                       input logic d, input logic e);
        tick = t; eval_valid = v; eval_down = d; eval_err = e;
        @(posedge clk);
        #1;
        tick = 1'b0; eval_valid = 1'b0; eval_down = 1'b0; eval_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic settle();
        repeat (8) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [2:0] s, input int a, input int f);
        exp_t x;
        x.stb = s;
        x.a   = 8'(a);
        x.f   = 8'(f);
        sbq.push_back(x);
    endtask

    // Monitor: every strobe must match the head of the scoreboard, and
    // the levels one cycle later must match the predicted values.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (amp_dec || freq_inc || freq_dec) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got %b expected none",
                             {amp_dec, freq_inc, freq_dec});
                end else begin
                    x = sbq.pop_front();
                    chk("strobe", 8'({amp_dec, freq_inc, freq_dec}),
                        8'(x.stb));
                    @(negedge clk);
                    chk("A_after", 8'(A), x.a);
                    chk("F_after", 8'(F), x.f);
                end
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_A", 8'(A), 8'd4);
        chk("rst_F", 8'(F), 8'd4);
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_fault", 8'(fault), 8'd0);

        // Settle: eval ignored, 7 ticks not enough, 8th moves on.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("settle_7", 8'(state), 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("settle_8", 8'(state), 8'd1);

        // Plain evaluation: frequency down.
        push(X_DEC, 4, 3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_step", 8'(state), 8'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_settle", 8'(state), 8'd0);

        // Two decreases: first arms, second steps amplitude.
        settle();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_arm", 8'(state), 8'd0);
        chk("t3_A", 8'(A), 8'd4);
        settle();
        push(X_AMP, 3, 3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Errors: step up, saturate, then fault on the third.
        settle();
        push(X_INC, 3, 4);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_e1", 8'(state), 8'd0);
        settle();
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_e2_sat", 8'(state), 8'd0);
        settle();
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_fault", 8'(fault), 8'd1);
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_sticky", 8'(state), 8'd4);
        chk("t4_A_held", 8'(A), 8'd3);
        chk("t4_F_held", 8'(F), 8'd4);

        // Timeout in WAIT_EVAL.
        do_reset();
        settle();
        repeat (15) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_15", 8'(state), 8'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_timeout", 8'(fault), 8'd1);

        // Eval on the 16th tick beats the timeout.
        do_reset();
        settle();
        repeat (15) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(X_DEC, 4, 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_race_step", 8'(state), 8'd2);
        chk("t5_race_fault", 8'(fault), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Run F to 0, then A to 0.
        for (int i = 2; i >= 0; i--) begin
            settle();
            push(X_DEC, 4, i);
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 3; i >= 0; i--) begin
            settle();
            push(X_AMP, i, 0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t6_done", 8'(done), 8'd1);
        chk("t6_state", 8'(state), 8'd3);
        settle();
        chk("t6_done_sticky", 8'(done), 8'd1);

        // Reset landing on the STEP cycle.
        do_reset();
        settle();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_rst_strobe", 8'(freq_dec), 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_rst_A", 8'(A), 8'd4);
        chk("t6_rst_F", 8'(F), 8'd4);
        chk("t6_rst_state", 8'(state), 8'd0);

        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_empty", 8'(sbq.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
